// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: one 128-bit cache line, 16-bit word
// address, and the per-byte write mask that goes with a line.
package lc3b_types;

  typedef logic [127:0] lc3b_line;
  typedef logic [15:0]  lc3b_word;
  typedef logic [15:0]  lc3b_mask;

  // A line is 16 bytes; word addresses carry 3 offset bits below the index.
  localparam int unsigned LINE_BYTES  = 16;
  localparam int unsigned LINE_OFFSET = 3;

endpackage

// File: rtl/line_store.sv
// Line storage: DEPTH_LINES x 128 bits, asynchronous read port and a
// byte-enabled synchronous write port. Contents start at zero and are
// never cleared by reset.
module line_store
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH_LINES = 256
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_LINES)-1:0] rd_idx_i,
  output lc3b_line                       rd_data_o,
  input  logic                           wr_en_i,
  input  logic [$clog2(DEPTH_LINES)-1:0] wr_idx_i,
  input  lc3b_line                       wr_data_i,
  input  lc3b_mask                       wr_sel_i
);

  lc3b_line mem_q [DEPTH_LINES] = '{default: '0};

  assign rd_data_o = mem_q[rd_idx_i];

  // Byte-merged write: only the selected byte lanes of the line change.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int b = 0; b < LINE_BYTES; b++) begin
        if (wr_sel_i[b]) begin
          mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/line_memory_responder.sv
// Line memory slave for a cache master. A request (stb&cyc in IDLE) is
// latched, waits LATENCY-1 BUSY cycles, then answers with a one-cycle ack
// in RESPOND. Dropping stb or cyc while BUSY aborts the transfer.
//
// Handshake: the master holds stb&cyc (and may change any other input)
// until it sees ack; the request fields are captured at acceptance only.
// ack is a single-cycle pulse; the master must drop stb after it or the
// next cycle in IDLE accepts a fresh request.
module line_memory_responder
  import lc3b_types::*;
#(
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned DEPTH_LINES = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  lc3b_word   adr,
  input  lc3b_line   dat_m,
  input  lc3b_mask   sel,
  input  logic       stb,
  input  logic       cyc,
  input  logic       we,
  output lc3b_line   dat_s,
  output logic       ack,
  output logic [1:0] state_dbg_o
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_LINES);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q;
  logic             we_q;
  lc3b_mask         sel_q;
  lc3b_line         wdata_q;
  lc3b_line         dat_s_q;
  lc3b_line         rd_line;
  logic             accept;
  logic             store_wr_en;
  logic             unused_adr_bits;

  // Offset bits and bits above the index alias onto the same line.
  assign unused_adr_bits = ^{adr[15:LINE_OFFSET+IDX_W], adr[LINE_OFFSET-1:0]};

  assign accept = (state_q == IDLE) && stb && cyc;

  // State and latency counter; reset wins over a coincident request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: count down in BUSY, abort if the master lets go.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? RESPOND : BUSY;
        end
      end
      BUSY: begin
        if (!(stb && cyc)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = RESPOND;
          end
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: ack for the RESPOND cycle, write commit at its end, and the
  // read line shown live during a read ack then held in dat_s_q.
  always_comb begin
    ack         = (state_q == RESPOND);
    store_wr_en = (state_q == RESPOND) && we_q && !rst;
    dat_s       = ((state_q == RESPOND) && !we_q) ? rd_line : dat_s_q;
    state_dbg_o = state_q;
  end

  // Request capture at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= adr[LINE_OFFSET +: IDX_W];
      we_q    <= we;
      sel_q   <= sel;
      wdata_q <= dat_m;
    end
  end

  // Read data holding register, updated only by a completed read.
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_s_q <= '0;
    end else if ((state_q == RESPOND) && !we_q) begin
      dat_s_q <= rd_line;
    end
  end

  line_store #(
    .DEPTH_LINES(DEPTH_LINES)
  ) u_line_store (
    .clk       (clk),
    .rd_idx_i  (idx_q),
    .rd_data_o (rd_line),
    .wr_en_i   (store_wr_en),
    .wr_idx_i  (idx_q),
    .wr_data_i (wdata_q),
    .wr_sel_i  (sel_q)
  );

endmodule

// File: tb/tb_line_memory_responder.sv
// Directed bench for line_memory_responder: one LATENCY=4 and one LATENCY=1
// instance share the same master inputs.
module tb_line_memory_responder;

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D2 = 128'h0123456789ABCDEF0123456789ABCDAA;
  localparam logic [127:0] D3 = 128'hDEADBEEFCAFEF00D123456789ABCDEF0;
  localparam logic [127:0] D4 = 128'h012345670000000000000000_89ABCDEF;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0]  adr;
  logic [127:0] dat_m;
  logic [15:0]  sel;
  logic         stb, cyc, we;
  logic [127:0] dat_s4, dat_s1;
  logic         ack4, ack1;
  logic [1:0]   state4, state1;

  int n_checks = 0;
  int n_fail   = 0;

  line_memory_responder #(.LATENCY(4), .DEPTH_LINES(256)) u_dut4 (
    .clk(clk), .rst(rst), .adr(adr), .dat_m(dat_m), .sel(sel),
    .stb(stb), .cyc(cyc), .we(we), .dat_s(dat_s4), .ack(ack4),
    .state_dbg_o(state4)
  );

  line_memory_responder #(.LATENCY(1), .DEPTH_LINES(256)) u_dut1 (
    .clk(clk), .rst(rst), .adr(adr), .dat_m(dat_m), .sel(sel),
    .stb(stb), .cyc(cyc), .we(we), .dat_s(dat_s1), .ack(ack1),
    .state_dbg_o(state1)
  );

  // scoreboard check
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: one transfer on the LATENCY=4 instance, scrambling inputs after
  // acceptance; returns ack latency, dat_s in the ack cycle, ack one cycle later
  task automatic xfer(input logic w, input logic [15:0] a, input logic [127:0] d,
                      input logic [15:0] s, output int lat, output logic [127:0] rdata,
                      output logic ack_after);
    lat   = -1;
    rdata = '0;
    adr = a; dat_m = d; sel = s; we = w; stb = 1'b1; cyc = 1'b1;
    step();
    adr   = 16'($urandom);
    dat_m = {$urandom, $urandom, $urandom, $urandom};
    sel   = 16'($urandom);
    we    = 1'($urandom_range(0, 1));
    for (int k = 1; k <= 20; k++) begin
      if (ack4) begin
        lat   = k;
        rdata = dat_s4;
        break;
      end
      step();
    end
    stb = 1'b0; cyc = 1'b0;
    step();
    ack_after = ack4;
  endtask

  task automatic do_read(input string tag, input logic [15:0] a, input logic [127:0] exp);
    int lat; logic [127:0] rd; logic aa;
    xfer(1'b0, a, '0, '0, lat, rd, aa);
    check_eq({tag, "_lat"}, lat, 4);
    check_eq({tag, "_data"}, rd, exp);
    check_eq({tag, "_ack_pulse"}, aa, 0);
  endtask

  task automatic do_write(input string tag, input logic [15:0] a, input logic [127:0] d,
                          input logic [15:0] s);
    int lat; logic [127:0] rd; logic aa;
    xfer(1'b1, a, d, s, lat, rd, aa);
    check_eq({tag, "_lat"}, lat, 4);
    check_eq({tag, "_ack_pulse"}, aa, 0);
  endtask

  task automatic count_acks(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (ack4) n++;
    end
  endtask

  initial begin
    int n_ack;
    int n4, first4, last4, bad4, n1, alt_bad;
    logic prev1;

    // reset with a request held high: reset must win
    rst = 1'b1; stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = '0; dat_m = '0; sel = '0;
    step(); step();
    check_eq("rst_ack4", ack4, 0);
    check_eq("rst_dat_s4", dat_s4, 0);
    check_eq("rst_state4", state4, 0);
    check_eq("rst_ack1", ack1, 0);
    stb = 1'b0; cyc = 1'b0;
    step();
    rst = 1'b0;
    step();

    // cold read, full write, line-aligned read back
    do_read("rd_cold", 16'h0010, 128'h0);
    do_write("wr_full", 16'h0018, D1, 16'hFFFF);
    check_eq("wr_keeps_dat_s", dat_s4, 0);
    do_read("rd_full", 16'h001F, D1);

    // single-byte write merges into the line
    do_write("wr_byte", 16'h0018, {{15{8'h55}}, 8'hAA}, 16'h0001);
    do_read("rd_byte", 16'h0018, D2);

    // abort: drop stb in the second BUSY cycle
    adr = 16'h0018; dat_m = '1; sel = '1; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    step();
    step();
    stb = 1'b0; cyc = 1'b0;
    count_acks(8, n_ack);
    check_eq("abort_no_ack", n_ack, 0);
    check_eq("abort_state", state4, 0);
    do_read("abort_rd", 16'h0018, D2);

    // reset in BUSY of a write
    adr = 16'h0018; dat_m = '1; sel = '1; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    step();
    rst = 1'b1;
    step();
    check_eq("rstmid_dat_s", dat_s4, 0);
    check_eq("rstmid_state", state4, 0);
    rst = 1'b0; stb = 1'b0; cyc = 1'b0;
    count_acks(8, n_ack);
    check_eq("rstmid_no_ack", n_ack, 0);
    do_read("rstmid_rd", 16'h0018, D2);

    // address aliasing modulo DEPTH_LINES
    do_write("wr_alias", 16'h0008, D3, 16'hFFFF);
    do_read("rd_alias", 16'h0808, D3);

    // dat_s holds across a write; partial write onto a zero line
    do_write("wr_part", 16'h0020, D1, 16'hF00F);
    check_eq("hold_dat_s", dat_s4, D3);
    do_read("rd_part", 16'h0020, D4);

    // stb held continuously: spacing LATENCY+1 on both instances
    adr = '0; we = 1'b0; sel = '0; dat_m = '0; stb = 1'b1; cyc = 1'b1;
    n4 = 0; first4 = 0; last4 = 0; bad4 = 0; n1 = 0; alt_bad = 0; prev1 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (ack4) begin
        n4++;
        if (first4 == 0) first4 = i;
        else if (i - last4 != 5) bad4++;
        last4 = i;
      end
      if (ack1) n1++;
      if (ack1 == prev1) alt_bad++;
      prev1 = ack1;
    end
    stb = 1'b0; cyc = 1'b0;
    step();
    check_eq("b2b4_first", first4, 4);
    check_eq("b2b4_count", n4, 4);
    check_eq("b2b4_gap", bad4, 0);
    check_eq("b2b1_count", n1, 10);
    check_eq("b2b1_alternate", alt_bad, 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_memory_responder.md
LINE_MEMORY_RESPONDER -- requirements
Module: line_memory_responder

Interface
REQ-001 Parameter LATENCY, default 4: cycles from request acceptance to ACK; legal range 1..15.
REQ-002 Parameter DEPTH_LINES, default 256: number of 128-bit lines held; power of two.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 adr  input  16  word address from cache master; bits [2:0] ignored (line-aligned).
REQ-006 dat_m  input  128  write line from master.
REQ-007 sel  input  16  byte enables for writes; bit i covers dat_m[8i+7:8i].
REQ-008 stb  input  1  strobe; request valid.
REQ-009 cyc  input  1  bus cycle active.
REQ-010 we  input  1  1 = write, 0 = read.
REQ-011 dat_s  output  128  read line to master.
REQ-012 ack  output  1  transfer complete, one-cycle pulse.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, RESPOND.
REQ-014 In IDLE, stb&cyc high at a rising edge SHALL accept the request: latch adr, we, sel, dat_m, load latency counter with LATENCY-1, go to BUSY (or directly to RESPOND when LATENCY=1).
REQ-015 Line index SHALL be adr[3+log2(DEPTH_LINES)-1:3]; higher address bits ignored (addresses alias, wrap modulo DEPTH_LINES).
REQ-016 In BUSY the counter SHALL decrement each cycle; at zero go to RESPOND.
REQ-017 ack SHALL be high for exactly the one cycle in RESPOND; request accepted in cycle t SHALL produce ack in cycle t+LATENCY.
REQ-018 Read: dat_s SHALL equal the stored line at the latched index during the ack cycle and SHALL hold that value until the next read ack or reset.
REQ-019 Write: the latched line SHALL be committed at the end of the RESPOND cycle, only bytes with latched sel bit set; dat_s unchanged by writes.
REQ-020 Inputs changing after acceptance (adr, we, sel, dat_m) SHALL have no effect on the in-flight transfer.
REQ-021 Abort: if stb or cyc is low in any BUSY cycle, SHALL return to IDLE, no ack, no write.
REQ-022 From RESPOND the FSM SHALL always go to IDLE; stb still high in the cycle after ack SHALL be accepted as a new request (master must drop stb after ack).
REQ-023 Back-to-back: minimum spacing between two acks SHALL be LATENCY+1 cycles.
REQ-024 Read after write to same line SHALL return the written bytes merged with prior unselected bytes.
REQ-025 Memory contents SHALL be zero at time zero.

Reset
REQ-026 rst high at a rising edge SHALL force IDLE, ack=0, dat_s=0, counter=0.
REQ-027 Reset mid-transfer SHALL discard the pending request: no ack, no write.
REQ-028 Reset SHALL NOT clear memory contents.
REQ-029 rst SHALL take priority over a simultaneous stb&cyc request.

Structure
REQ-030 The 128-bit line type and the 16-bit address type SHALL come from the shared lc3b_types package; FSM state enum stays local.
REQ-031 Storage SHALL be a single sub-module line_store (DEPTH_LINES x 128, one read port, one byte-enabled write port, synchronous write).
REQ-032 Implementation target: 120-400 lines RTL including line_store.

Verification
REQ-033 Reset then read adr 16'h0010, LATENCY=4 -> ack in cycle t+4 only, dat_s=128'h0.
REQ-034 Write adr 16'h0018, dat_m=128'h0123..CDEF, sel=16'hFFFF, then read 16'h001F -> dat_s=128'h0123..CDEF.
REQ-035 Write sel=16'h0001 dat_m low byte 8'hAA to line above, read -> only byte 0 = 8'hAA, others unchanged.
REQ-036 Accept write, drop stb in second BUSY cycle -> no ack ever, subsequent read shows old data.
REQ-037 Assert rst during BUSY of a write -> no ack, dat_s=0, memory unchanged; write to adr 16'h0008 with DEPTH_LINES=256 then read 16'h0808 -> same data (alias).
REQ-038 LATENCY=1, stb held high continuously -> ack pulses every second cycle.
